// File: rtl/connect4_move_sequencer_pkg.sv
// Shared definitions for the Connect-4 turn controller: FSM states, result codes
// and board geometry.
package connect4_move_sequencer_pkg;

    localparam int BOARD_COLS  = 4;
    localparam int BOARD_ROWS  = 4;
    localparam int BOARD_CELLS = BOARD_COLS * BOARD_ROWS;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_VALIDATE = 3'd1,
        S_WRITE    = 3'd2,
        S_CHECK    = 3'd3,
        S_RELEASE  = 3'd4,
        S_OVER     = 3'd5
    } state_t;

    // Shared by the detector's win_status and the latched final winner.
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/connect4_move_sequencer_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, level debouncer and a one-cycle press
// strobe on the rising edge of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;
    logic          settle;

    assign settle = (cnt == CW'(DEBOUNCE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            // Any sample agreeing with the current level restarts the run.
            if (sync_p1 != level) begin
                if (settle) begin
                    level <= sync_p1;
                    cnt   <= '0;
                    press <= sync_p1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/connect4_move_sequencer.sv
// Turn controller: validates a column drop against the fill heights, strobes
// the board write, waits for the winner detector, then alternates or ends.
module connect4_move_sequencer
    import connect4_move_sequencer_pkg::*;
#(
    parameter int COLS      = BOARD_COLS,
    parameter int ROWS      = BOARD_ROWS,
    parameter int DEBOUNCE  = 4,
    parameter int CHECK_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            btn,
    input  logic [COLS-1:0] col_sel,
    input  logic [1:0]      win_status,
    output logic            cell_wr_en,
    output logic [3:0]      cell_idx,
    output logic            player,
    output logic [4:0]      move_cnt,
    output logic            bad_move,
    output logic            game_over,
    output logic [1:0]      winner,
    output logic [2:0]      fsm_state
);

    localparam int CW = $clog2(COLS);
    localparam int HW = $clog2(ROWS + 1);
    localparam int WW = $clog2(CHECK_LAT) + 1;

    function automatic logic is_onehot(input logic [COLS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < COLS; i++) n += int'(v[i]);
        return (n == 1);
    endfunction

    function automatic logic [CW-1:0] onehot_idx(input logic [COLS-1:0] v);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < COLS; i++) if (v[i]) r = CW'(i);
        return r;
    endfunction

    state_t          state;
    state_t          state_nx;
    logic [COLS-1:0] sel_q;
    logic [HW-1:0]   height [COLS];
    logic [WW-1:0]   wait_cnt;
    logic            press;
    logic            level;
    logic [CW-1:0]   col;
    logic            legal;
    logic            win_hit;
    logic            board_full;
    logic [3:0]      wr_idx;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_btn (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .level (level),
        .press (press)
    );

    assign col        = onehot_idx(sel_q);
    assign legal      = is_onehot(sel_q) && (height[col] < HW'(ROWS));
    assign win_hit    = (win_status == WIN_P0) || (win_status == WIN_P1);
    assign board_full = (move_cnt == 5'(COLS * ROWS));
    assign wr_idx     = 4'(int'(col) * ROWS + int'(height[col]));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (press) state_nx = S_VALIDATE;
            S_VALIDATE: state_nx = legal ? S_WRITE : S_RELEASE;
            S_WRITE:    state_nx = S_CHECK;
            S_CHECK:    if (wait_cnt == '0) state_nx = (win_hit || board_full) ? S_OVER : S_RELEASE;
            S_RELEASE:  if (!level) state_nx = S_IDLE;
            S_OVER:     state_nx = S_OVER;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cell_wr_en = (state == S_WRITE);
        cell_idx   = cell_wr_en ? wr_idx : 4'd0;
        bad_move   = (state == S_VALIDATE) && !legal;
        game_over  = (state == S_OVER);
        fsm_state  = state;
    end

    // Move bookkeeping; sel_q freezes the selection so later switch changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q    <= '0;
            wait_cnt <= '0;
            move_cnt <= '0;
            player   <= 1'b0;
            winner   <= WIN_NONE;
            for (int i = 0; i < COLS; i++) height[i] <= '0;
        end else begin
            case (state)
                S_IDLE: if (press) sel_q <= col_sel;
                S_WRITE: begin
                    height[col] <= height[col] + 1'b1;
                    move_cnt    <= move_cnt + 1'b1;
                    wait_cnt    <= WW'(CHECK_LAT - 1);
                end
                S_CHECK: begin
                    if (wait_cnt != '0)  wait_cnt <= wait_cnt - 1'b1;
                    else if (win_hit)    winner   <= win_status;
                    else if (board_full) winner   <= WIN_DRAW;
                    else                 player   <= ~player;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_connect4_move_sequencer.sv
// Directed and randomized bench for connect4_move_sequencer against a
// game-level reference model of the board, turn and result.
module tb_connect4_move_sequencer;

    localparam int CHECK_LAT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn = 1'b0;
    logic [3:0] col_sel = 4'd0;
    logic [1:0] win_status = 2'b00;
    logic       cell_wr_en;
    logic [3:0] cell_idx;
    logic       player;
    logic [4:0] move_cnt;
    logic       bad_move;
    logic       game_over;
    logic [1:0] winner;
    logic [2:0] fsm_state;

    connect4_move_sequencer #(.COLS(4), .ROWS(4), .DEBOUNCE(4), .CHECK_LAT(CHECK_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .col_sel    (col_sel),
        .win_status (win_status),
        .cell_wr_en (cell_wr_en),
        .cell_idx   (cell_idx),
        .player     (player),
        .move_cnt   (move_cnt),
        .bad_move   (bad_move),
        .game_over  (game_over),
        .winner     (winner),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: column heights, moves made, side to move, result.
    int         m_h [4];
    int         m_cnt;
    logic       m_player;
    logic [1:0] m_winner;
    logic       m_over;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) m_h[c] = 0;
        m_cnt = 0;
        m_player = 1'b0;
        m_winner = 2'b00;
        m_over = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, 32'(cell_wr_en), 32'd0);
        check({tag, "_idx"},   32'(cell_idx),   32'd0);
        check({tag, "_player"},32'(player),     32'd0);
        check({tag, "_cnt"},   32'(move_cnt),   32'd0);
        check({tag, "_bad"},   32'(bad_move),   32'd0);
        check({tag, "_over"},  32'(game_over),  32'd0);
        check({tag, "_winner"},32'(winner),     32'd0);
        check({tag, "_state"}, 32'(fsm_state),  32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        btn = 1'b0;
        col_sel = 4'd0;
        win_status = 2'b00;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    // One full press/release; win_status carries ws only in the cycle the
    // detector result is due after a write.
    task automatic press(input logic [3:0] cs, input logic [1:0] ws);
        int   writes = 0;
        int   bads = 0;
        int   excl = 0;
        int   wr_at = -1;
        int   idx = 0;
        int   pl = 0;
        int   col = 0;
        logic legal;
        col_sel = cs;
        btn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cell_wr_en) begin
                writes++;
                wr_at = i;
                idx = int'(cell_idx);
                pl = int'(player);
            end
            if (bad_move) bads++;
            if (cell_wr_en && bad_move) excl++;
            win_status = (wr_at >= 0 && i == wr_at + CHECK_LAT) ? ws : 2'b00;
            if (i == 10) col_sel = 4'($urandom);
            if (i == 12) btn = 1'b0;
        end
        win_status = 2'b00;
        for (int c = 0; c < 4; c++) if (cs[c]) col = c;
        legal = ($countones(cs) == 1) && (m_h[col] < 4);
        if (m_over) begin
            check("over_writes", 32'(writes), 32'd0);
            check("over_bad", 32'(bads), 32'd0);
        end else if (legal) begin
            check("writes", 32'(writes), 32'd1);
            check("bad_on_legal", 32'(bads), 32'd0);
            check("cell_idx", 32'(idx), 32'(col * 4 + m_h[col]));
            check("write_player", 32'(pl), 32'(m_player));
            m_h[col]++;
            m_cnt++;
            if (ws == 2'b01 || ws == 2'b10) begin
                m_winner = ws;
                m_over = 1'b1;
            end else if (m_cnt == 16) begin
                m_winner = 2'b11;
                m_over = 1'b1;
            end else begin
                m_player = ~m_player;
            end
        end else begin
            check("illegal_writes", 32'(writes), 32'd0);
            check("illegal_bad", 32'(bads), 32'd1);
        end
        check("exclusive", 32'(excl), 32'd0);
        check("move_cnt", 32'(move_cnt), 32'(m_cnt));
        check("player", 32'(player), 32'(m_player));
        check("winner", 32'(winner), 32'(m_winner));
        check("game_over", 32'(game_over), 32'(m_over));
        check("state", 32'(fsm_state), m_over ? 32'd5 : 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] rcs;
        logic [1:0] rws;
        logic       seen;

        model_reset();
        @(negedge clk);
        do_reset();

        // Short glitch: three high samples never reach the debounce threshold.
        btn = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 2) btn = 1'b0;
            check("glitch_state", 32'(fsm_state), 32'd0);
            check("glitch_wr", 32'(cell_wr_en), 32'd0);
        end

        press(4'b0001, 2'b00);
        for (int k = 0; k < 4; k++) press(4'b0100, 2'b00);
        press(4'b0100, 2'b00);
        press(4'b0011, 2'b00);
        press(4'b0000, 2'b00);

        // Player-1 win on the second move, then presses are ignored.
        do_reset();
        press(4'b0001, 2'b00);
        press(4'b0010, 2'b10);
        press(4'b0001, 2'b00);
        press(4'b1111, 2'b00);
        do_reset();

        // Full board with no winner, then the same board won on the last move.
        for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) press(4'(1 << c), 2'b00);
        press(4'b0001, 2'b00);
        do_reset();
        for (int n = 0; n < 16; n++) press(4'(1 << (n % 4)), (n == 15) ? 2'b01 : 2'b00);
        do_reset();

        // Randomized game.
        for (int n = 0; n < 30; n++) begin
            rcs = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) rws = 2'($urandom_range(1, 2));
            else rws = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
            press(rcs, rws);
        end
        do_reset();

        // Reset in the middle of a move leaves an empty board.
        seen = 1'b0;
        col_sel = 4'b0001;
        btn = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (cell_wr_en) seen = 1'b1;
        end
        check("midmove_reached", 32'(seen), 32'd1);
        do_reset();
        repeat (8) @(negedge clk);
        press(4'b0001, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
